read_master_pipe: RTL and testbench
===================================

Name: read_master_pipe

Overview:
- Parametrised pipelined read master for the memory-mapped bus; successor of the single-outstanding-window read pipeline.
- Reads a contiguous byte region starting at a given address. Issues word reads back-to-back, with up to MAX_OUTS requests in flight.
- Forwards returned data into the downstream FIFO write port.
- Credit-based flow control against FIFO free space, a clean abort, and a one-cycle done pulse replace the sticky done of the previous generation.

Parameters:
- ADDR_W, 32, address and length width.
- DATA_W, 32, bus data width; a power of 2, at least 8. BYTES = DATA_W/8.
- MAX_OUTS, 4, maximum accepted-but-unreturned reads; at least 1.
- SPACE_W, 8, width of the FIFO free-space input.

Ports:
- iClk  in  1  clock
- iRst  in  1  asynchronous active-high reset
- iStart  in  1  start request; sampled only in IDLE
- iAbort  in  1  stop issuing; drain, then finish
- iRead_Addr  in  ADDR_W  start byte address; low log2(BYTES) bits are forced to 0 when latched
- iLength  in  ADDR_W  transfer length in bytes
- iWait  in  1  slave waitrequest
- iRd_Data_valid  in  1  read data valid
- iRd_Data  in  DATA_W  read data
- iFF_space  in  SPACE_W  free entries in the downstream FIFO
- oRead  out  1  read request
- oRead_Addr  out  ADDR_W  request address
- oFF_wr  out  1  FIFO write strobe
- oFF_data  out  DATA_W  FIFO write data
- oBusy  out  1  high from the cycle after start acceptance until the done pulse
- oDone  out  1  one-cycle completion pulse
- oAborted  out  1  valid with oDone; transfer ended early
- oErr  out  1  sticky; data arrived with nothing outstanding; cleared by the next accepted start

Behaviour:
- Reset: every output is 0, state is IDLE, all counters are 0. Reset mid-transfer abandons the transfer with no done pulse.
- Derived quantities:
  - words = ceil(iLength/BYTES), computed at start.
  - accept = oRead & ~iWait.
  - outs counter width = clog2(MAX_OUTS+1).
  - outs update: +1 on accept, -1 on iRd_Data_valid, unchanged when both occur in the same cycle.
- IDLE:
  - iStart=1 latches the aligned address and words, clears oErr, sets oBusy next cycle.
  - If words=0, go to FINISH instead of ISSUE.
- ISSUE:
  - oRead is asserted (registered) when all of these hold: remaining>0, outs<MAX_OUTS, outs<iFF_space, no abort pending.
  - While oRead=1 and iWait=1, oRead and oRead_Addr hold stable. The request is never withdrawn, even on iAbort.
  - On accept: address += BYTES, remaining -= 1. Back-to-back accepts give 1 request per cycle.
  - When remaining reaches 0, or iAbort is seen with no unaccepted request, go to DRAIN.
  - iAbort is latched, so a one-cycle pulse is sufficient.
- DRAIN: no new requests. Wait for outs=0, then go to FINISH.
- FINISH: oDone=1 for one cycle, oAborted reflects the latched abort, oBusy drops in the same cycle. Next state is IDLE.
- Data path:
  - oFF_wr and oFF_data are iRd_Data_valid and iRd_Data registered, latency 1 cycle, in any state including IDLE.
  - The credit rule guarantees no FIFO overflow provided iFF_space reflects writes committed up to the previous cycle.
  - Valid with outs=0: data is still forwarded, oErr is set, and outs stays 0 (no underflow).
- iStart while oBusy is ignored.
- Address wraps modulo 2^ADDR_W, with no error.
- iFF_space=0 stalls issue indefinitely; no timeout.

Decomposition:
- Package read_master_pkg holds the state enum (IDLE, ISSUE, DRAIN, FINISH) and the clog2-based width constants.
- One natural sub-module, outs_counter: an up/down saturating counter with a simultaneous inc/dec rule and an underflow flag.

Test Plan:
- Basic transfer.
  - Stimulus: addr=0x100, len=16, iWait=0, data returns 2 cycles after each accept, iFF_space=16.
  - Required: 4 reads at 0x100, 0x104, 0x108, 0x10C on consecutive cycles; 4 FIFO writes in order; a single oDone pulse after the last write; oAborted=0.
- Wait hold and outstanding limit.
  - Stimulus: len=32, iWait high 3 cycles on the 2nd request, data withheld.
  - Required: oRead_Addr is stable at 0x104 for all 3 stall cycles; oRead deasserts once outs=4 and stays low until data returns.
- Credit stall.
  - Stimulus: iFF_space=2, len=32.
  - Required: never more than 2 outstanding; issue resumes when iFF_space rises to 8.
- Edge lengths.
  - len=0 -> oDone one cycle after start, no oRead.
  - len=5 -> 2 reads.
  - addr=0x103 -> first oRead_Addr=0x100.
- Abort.
  - Stimulus: iAbort pulse during a held request, with 3 requests accepted.
  - Required: the held request completes; 4 data beats are drained; oDone with oAborted=1; outs=0 at the end.
- Error and reset.
  - Valid injected in IDLE -> oErr=1, FIFO write occurs; the next start clears oErr.
  - iRst asserted mid-ISSUE -> all outputs 0 immediately (asynchronous), no oDone.

Source files
------------

// File: rtl/read_master_pkg.sv
`default_nettype none
// ============================================================
// Package : read_master_pkg
// State encoding and width helpers for the pipelined read master.
// Rev     : 1.0
// ============================================================
package read_master_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } state_t;

    // Counter must be able to hold the value MAX_OUTS itself.
    function automatic int outs_width(input int max_outs);
        return $clog2(max_outs + 1);
    endfunction

    function automatic int byte_lsb(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage
`default_nettype wire

// File: rtl/outs_counter.sv
`default_nettype none
// ============================================================
// Module : outs_counter
// Saturating up/down counter of reads in flight; flags a decrement at 0.
// Rev    : 1.0
// ============================================================
module outs_counter #(
    parameter int MAX = 4,
    parameter int W   = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_inc,
    input  logic         i_dec,
    output logic [W-1:0] o_count,
    output logic [W-1:0] o_count_nxt,
    output logic         o_underflow
);
    localparam logic [W-1:0] C_MAX = W'(MAX);

    logic [W-1:0] r_count;

    // Simultaneous inc/dec cancel; both ends saturate.
    always_comb begin
        o_count_nxt = r_count;
        if (i_inc && !i_dec && (r_count != C_MAX)) begin
            o_count_nxt = r_count + W'(1);
        end else if (i_dec && !i_inc && (r_count != '0)) begin
            o_count_nxt = r_count - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            r_count <= o_count_nxt;
        end
    end

    assign o_count     = r_count;
    assign o_underflow = i_dec && (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/read_master_pipe.sv
`default_nettype none
// ============================================================
// Module : read_master_pipe
// Pipelined word read master with FIFO credit flow control and abort.
// Rev    : 1.0
// ============================================================
module read_master_pipe
    import read_master_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_OUTS = 4,
    parameter int SPACE_W  = 8
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iStart,
    input  logic              iAbort,
    input  logic [ADDR_W-1:0] iRead_Addr,
    input  logic [ADDR_W-1:0] iLength,
    input  logic              iWait,
    input  logic              iRd_Data_valid,
    input  logic [DATA_W-1:0] iRd_Data,
    input  logic [SPACE_W-1:0] iFF_space,
    output logic              oRead,
    output logic [ADDR_W-1:0] oRead_Addr,
    output logic              oFF_wr,
    output logic [DATA_W-1:0] oFF_data,
    output logic              oBusy,
    output logic              oDone,
    output logic              oAborted,
    output logic              oErr
);
    localparam int BYTES  = DATA_W / 8;
    localparam int LSB    = byte_lsb(DATA_W);
    localparam int OUTS_W = outs_width(MAX_OUTS);
    localparam int CMP_W  = (OUTS_W > SPACE_W) ? OUTS_W : SPACE_W;
    localparam logic [ADDR_W-1:0] C_LOW_MASK = ADDR_W'(BYTES - 1);
    localparam logic [ADDR_W-1:0] C_STEP     = ADDR_W'(BYTES);
    localparam logic [OUTS_W-1:0] C_MAX_OUTS = OUTS_W'(MAX_OUTS);

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_addr, r_remaining, w_words, w_rem_after;
    logic              r_abort, r_read, r_busy, r_done, r_aborted, r_err;
    logic              r_ff_wr;
    logic [DATA_W-1:0] r_ff_data;
    logic              w_start, w_accept, w_held, w_abort_seen, w_can_issue;
    logic              w_read_nxt, w_busy_nxt, w_done_nxt, w_aborted_nxt;
    logic              w_underflow;
    logic [OUTS_W-1:0] w_outs, w_outs_nxt;

    assign w_start      = (r_state == IDLE) && iStart;
    assign w_accept     = r_read && !iWait;
    assign w_held       = r_read && iWait;
    assign w_words      = (iLength >> LSB) + ADDR_W'(|(iLength & C_LOW_MASK));
    assign w_rem_after  = r_remaining - ADDR_W'(w_accept);
    assign w_abort_seen = r_abort || ((r_state == ISSUE) && iAbort);

    outs_counter #(
        .MAX (MAX_OUTS),
        .W   (OUTS_W)
    ) u_outs (
        .clk         (iClk),
        .rst         (iRst),
        .i_inc       (w_accept),
        .i_dec       (iRd_Data_valid),
        .o_count     (w_outs),
        .o_count_nxt (w_outs_nxt),
        .o_underflow (w_underflow)
    );

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (iStart) w_state_nxt = (w_words == '0) ? FINISH : ISSUE;
            ISSUE:   if ((w_rem_after == '0) || (w_abort_seen && !w_held)) w_state_nxt = DRAIN;
            DRAIN:   if (w_outs == '0) w_state_nxt = FINISH;
            FINISH:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Credit check uses post-update counts so back-to-back accepts stay legal.
    always_comb begin
        w_can_issue   = (w_rem_after != '0) && (w_outs_nxt < C_MAX_OUTS) &&
                        (CMP_W'(w_outs_nxt) < CMP_W'(iFF_space)) && !w_abort_seen;
        w_read_nxt    = w_held || ((r_state == ISSUE) && (w_state_nxt == ISSUE) && w_can_issue);
        w_busy_nxt    = (w_state_nxt == ISSUE) || (w_state_nxt == DRAIN);
        w_done_nxt    = (w_state_nxt == FINISH);
        w_aborted_nxt = (w_state_nxt == FINISH) && w_abort_seen;
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_abort     <= 1'b0;
            r_read      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_aborted   <= 1'b0;
            r_err       <= 1'b0;
            r_ff_wr     <= 1'b0;
            r_ff_data   <= '0;
        end else begin
            r_read    <= w_read_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_aborted <= w_aborted_nxt;
            r_ff_wr   <= iRd_Data_valid;
            r_ff_data <= iRd_Data;
            if (w_start) begin
                r_addr      <= iRead_Addr & ~C_LOW_MASK;
                r_remaining <= w_words;
                r_abort     <= 1'b0;
            end else begin
                if (w_accept) begin
                    r_addr      <= r_addr + C_STEP;
                    r_remaining <= w_rem_after;
                end
                if ((r_state == ISSUE) && iAbort) begin
                    r_abort <= 1'b1;
                end
            end
            if (w_underflow) begin
                r_err <= 1'b1;
            end else if (w_start) begin
                r_err <= 1'b0;
            end
        end
    end

    assign oRead      = r_read;
    assign oRead_Addr = r_addr;
    assign oFF_wr     = r_ff_wr;
    assign oFF_data   = r_ff_data;
    assign oBusy      = r_busy;
    assign oDone      = r_done;
    assign oAborted   = r_aborted;
    assign oErr       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_read_master_pipe.sv
`default_nettype none
// ============================================================
// Module : tb_read_master_pipe
// Self-checking bench: slave model with scoreboard, vector table, corner sequences.
// Rev    : 1.0
// ============================================================
module tb_read_master_pipe;
    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int MAX_OUTS = 4;
    localparam int SPACE_W  = 8;

    logic              iClk = 1'b0;
    logic              iRst = 1'b1;
    logic              iStart = 1'b0;
    logic              iAbort = 1'b0;
    logic [ADDR_W-1:0] iRead_Addr = '0;
    logic [ADDR_W-1:0] iLength = '0;
    logic              iWait = 1'b0;
    logic              iRd_Data_valid = 1'b0;
    logic [DATA_W-1:0] iRd_Data = '0;
    logic [SPACE_W-1:0] iFF_space = 8'd16;
    logic              oRead, oFF_wr, oBusy, oDone, oAborted, oErr;
    logic [ADDR_W-1:0] oRead_Addr;
    logic [DATA_W-1:0] oFF_data;

    read_master_pipe #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTS(MAX_OUTS), .SPACE_W(SPACE_W)
    ) dut (
        .iClk(iClk), .iRst(iRst), .iStart(iStart), .iAbort(iAbort),
        .iRead_Addr(iRead_Addr), .iLength(iLength), .iWait(iWait),
        .iRd_Data_valid(iRd_Data_valid), .iRd_Data(iRd_Data), .iFF_space(iFF_space),
        .oRead(oRead), .oRead_Addr(oRead_Addr), .oFF_wr(oFF_wr), .oFF_data(oFF_data),
        .oBusy(oBusy), .oDone(oDone), .oAborted(oAborted), .oErr(oErr)
    );

    always #5 iClk = ~iClk;

    int cyc = 0;
    always @(posedge iClk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name, input int act, input int exp);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return {a[15:0] ^ 16'hA5C3, a[31:16] + 16'h0001};
    endfunction

    // ---------------- slave model + scoreboard ----------------
    typedef struct { int due; logic [DATA_W-1:0] data; } ret_t;
    ret_t              ret_q[$];
    logic [DATA_W-1:0] sb_q[$];
    logic [ADDR_W-1:0] exp_addr_q[$];
    ret_t              r_item;

    int n_acc = 0, n_wr = 0, done_cnt = 0, tb_outs = 0;
    int first_acc = 0, last_acc = 0, last_wr = 0, done_cyc = 0, start_cyc = 0;
    logic [ADDR_W-1:0] first_addr = '0;
    logic done_abt = 1'b0, prev_done = 1'b0;
    int outs_limit = MAX_OUTS, wait_idx = -1, wait_left = 0;
    bit hold_data = 1'b0, inject = 1'b0;

    always @(negedge iClk) begin
        if (oFF_wr) begin
            if (sb_q.size() == 0) fail("unexpected_ff_write", 1, 0);
            else check("ff_data", oFF_data, sb_q.pop_front());
            n_wr++;
            last_wr = cyc;
        end
        if (oDone) begin
            if (prev_done) fail("done_pulse_width", 2, 1);
            done_cnt++;
            done_cyc = cyc;
            done_abt = oAborted;
            check("busy_low_at_done", oBusy, 0);
        end
        prev_done = oDone;
        if (oRead && (n_acc == wait_idx) && (wait_left > 0)) begin
            iWait = 1'b1;
            wait_left--;
            if (exp_addr_q.size() > 0) check("held_addr", oRead_Addr, exp_addr_q[0]);
        end else begin
            iWait = 1'b0;
        end
        if (!hold_data && (ret_q.size() > 0) && (ret_q[0].due <= cyc)) begin
            r_item = ret_q.pop_front();
            iRd_Data_valid = 1'b1;
            iRd_Data = r_item.data;
            sb_q.push_back(r_item.data);
            tb_outs--;
        end else if (inject) begin
            iRd_Data_valid = 1'b1;
            iRd_Data = 32'hDEAD_BEEF;
            sb_q.push_back(32'hDEAD_BEEF);
            inject = 1'b0;
        end else begin
            iRd_Data_valid = 1'b0;
        end
        if (oRead && !iWait) begin
            if (exp_addr_q.size() == 0) fail("extra_read", n_acc + 1, n_acc);
            else check("read_addr", oRead_Addr, exp_addr_q.pop_front());
            ret_q.push_back('{due: cyc + 2, data: data_of(oRead_Addr)});
            if (n_acc == 0) begin
                first_acc  = cyc;
                first_addr = oRead_Addr;
            end
            last_acc = cyc;
            n_acc++;
            tb_outs++;
            if (tb_outs > outs_limit) fail("outstanding_limit", tb_outs, outs_limit);
        end
    end

    // ---------------- helpers ----------------
    task automatic start_xfer(input logic [31:0] addr, input logic [31:0] len);
        logic [31:0] base;
        int          words;
        base  = addr & ~32'd3;
        words = int'(len / 4) + ((len % 4) != 0 ? 1 : 0);
        for (int i = 0; i < words; i++) exp_addr_q.push_back(base + 32'(4 * i));
        n_acc = 0; n_wr = 0; done_cnt = 0;
        @(negedge iClk);
        iRead_Addr = addr; iLength = len; iStart = 1'b1; start_cyc = cyc;
        @(negedge iClk);
        iStart = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int k;
        k = 0;
        while ((done_cnt == 0) && (k < budget)) begin
            @(negedge iClk);
            k++;
        end
        if (done_cnt == 0) fail(name, 0, 1);
        repeat (3) @(negedge iClk);
    endtask

    task automatic wait_acc(input string name, input int n);
        int k;
        k = 0;
        while ((n_acc < n) && (k < 60)) begin
            @(negedge iClk);
            k++;
        end
        check(name, n_acc, n);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] len;
        logic [7:0]  space;
        int          exp_reads;
        logic [31:0] exp_first;
    } vec_t;
    vec_t vecs [6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{addr: 32'h100,       len: 32'd16, space: 8'd16, exp_reads: 4, exp_first: 32'h100};
        vecs[1] = '{addr: 32'h200,       len: 32'd5,  space: 8'd16, exp_reads: 2, exp_first: 32'h200};
        vecs[2] = '{addr: 32'h103,       len: 32'd4,  space: 8'd16, exp_reads: 1, exp_first: 32'h100};
        vecs[3] = '{addr: 32'h300,       len: 32'd0,  space: 8'd16, exp_reads: 0, exp_first: 32'h0};
        vecs[4] = '{addr: 32'hFFFF_FFF8, len: 32'd16, space: 8'd16, exp_reads: 4, exp_first: 32'hFFFF_FFF8};
        vecs[5] = '{addr: 32'h500,       len: 32'd1,  space: 8'd1,  exp_reads: 1, exp_first: 32'h500};

        repeat (3) @(negedge iClk);
        check("reset_ctl", {oRead, oBusy, oDone, oAborted, oErr, oFF_wr}, 6'b0);
        check("reset_addr", oRead_Addr, 0);
        check("reset_data", oFF_data, 0);
        iRst = 1'b0;
        repeat (2) @(negedge iClk);

        for (int v = 0; v < 6; v++) begin
            iFF_space = vecs[v].space;
            start_xfer(vecs[v].addr, vecs[v].len);
            wait_done("vec_done_timeout", 100);
            check("vec_reads", n_acc, vecs[v].exp_reads);
            check("vec_writes", n_wr, vecs[v].exp_reads);
            check("vec_done_count", done_cnt, 1);
            check("vec_aborted", done_abt, 0);
            check("vec_addr_left", exp_addr_q.size(), 0);
            if (vecs[v].exp_reads > 0) begin
                check("vec_first_addr", first_addr, vecs[v].exp_first);
                check("vec_done_after_last_write", done_cyc > last_wr, 1);
                if (vecs[v].space >= 8'd4)
                    check("vec_back_to_back", last_acc - first_acc, vecs[v].exp_reads - 1);
            end else begin
                check("zero_len_done_latency", done_cyc - start_cyc, 1);
            end
        end

        // Wait hold on 2nd request, data withheld to hit the outstanding cap.
        iFF_space = 8'd16; hold_data = 1'b1; wait_idx = 1; wait_left = 3;
        start_xfer(32'h100, 32'd32);
        repeat (15) @(negedge iClk);
        check("cap_reads", n_acc, 4);
        check("cap_oread_low", oRead, 0);
        check("cap_wait_consumed", wait_left, 0);
        hold_data = 1'b0; wait_idx = -1;
        wait_done("cap_done_timeout", 100);
        check("cap_total_reads", n_acc, 8);
        check("cap_total_writes", n_wr, 8);

        // Credit stall with a start pulse that must be ignored while busy.
        iFF_space = 8'd2; hold_data = 1'b1; outs_limit = 2;
        start_xfer(32'h400, 32'd32);
        repeat (12) @(negedge iClk);
        check("credit_reads", n_acc, 2);
        check("credit_oread_low", oRead, 0);
        iStart = 1'b1;
        @(negedge iClk);
        iStart = 1'b0;
        iFF_space = 8'd8; outs_limit = MAX_OUTS;
        repeat (8) @(negedge iClk);
        check("credit_resume_reads", n_acc, 4);
        hold_data = 1'b0;
        wait_done("credit_done_timeout", 100);
        check("credit_total_reads", n_acc, 8);
        check("credit_done_count", done_cnt, 1);

        // Abort pulse while the 4th request is held by iWait.
        iFF_space = 8'd16; hold_data = 1'b1; wait_idx = 3; wait_left = 8;
        start_xfer(32'h800, 32'd32);
        wait_acc("abort_pre_accepts", 3);
        repeat (2) @(negedge iClk);
        check("abort_req_held", {oRead, iWait}, 2'b11);
        iAbort = 1'b1;
        @(negedge iClk);
        iAbort = 1'b0;
        repeat (10) @(negedge iClk);
        check("abort_accepts", n_acc, 4);
        check("abort_oread_low", oRead, 0);
        hold_data = 1'b0; wait_idx = -1;
        wait_done("abort_done_timeout", 100);
        check("abort_writes", n_wr, 4);
        check("abort_flag", done_abt, 1);
        check("abort_outs_zero", tb_outs, 0);
        check("abort_unissued", exp_addr_q.size(), 4);
        exp_addr_q.delete();

        // Unsolicited data in IDLE, then the next start clears the error.
        n_wr = 0;
        inject = 1'b1;
        repeat (4) @(negedge iClk);
        check("err_set", oErr, 1);
        check("err_write_forwarded", n_wr, 1);
        start_xfer(32'h40, 32'd4);
        check("err_cleared", oErr, 0);
        wait_done("err_done_timeout", 100);
        check("err_xfer_writes", n_wr, 1);

        // Asynchronous reset in the middle of issuing.
        hold_data = 1'b1;
        start_xfer(32'h1000, 32'd64);
        wait_acc("rst_pre_accepts", 2);
        check("rst_busy_before", oBusy, 1);
        #2 iRst = 1'b1;
        #1;
        check("rst_async_ctl", {oRead, oBusy, oDone, oAborted, oErr, oFF_wr}, 6'b0);
        check("rst_async_addr", oRead_Addr, 0);
        ret_q.delete(); sb_q.delete(); exp_addr_q.delete();
        tb_outs = 0; done_cnt = 0;
        repeat (2) @(negedge iClk);
        iRst = 1'b0; hold_data = 1'b0;
        repeat (6) @(negedge iClk);
        check("rst_no_done", done_cnt, 0);
        check("rst_idle_after", {oRead, oBusy}, 2'b00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
